// File: rtl/apb_cmd_master_if.sv
// apb_cmd_master_if: command/response channels plus APB3 bus of the command master
interface apb_cmd_master_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              cmd_valid, cmd_ready, cmd_write;
    logic [ADDR_W-1:0] cmd_addr;
    logic [DATA_W-1:0] cmd_wdata;
    logic              rsp_valid, rsp_ready, rsp_err;
    logic [DATA_W-1:0] rsp_rdata;
    logic              PSEL, PENABLE, PWRITE, PREADY, PSLVERR;
    logic [ADDR_W-1:0] PADDR;
    logic [DATA_W-1:0] PWDATA, PRDATA;
    modport master (
        input  cmd_valid, cmd_write, cmd_addr, cmd_wdata, rsp_ready, PRDATA, PREADY, PSLVERR,
        output cmd_ready, rsp_valid, rsp_rdata, rsp_err, PSEL, PENABLE, PWRITE, PADDR, PWDATA
    );
    modport slave (
        output cmd_valid, cmd_write, cmd_addr, cmd_wdata, rsp_ready, PRDATA, PREADY, PSLVERR,
        input  cmd_ready, rsp_valid, rsp_rdata, rsp_err, PSEL, PENABLE, PWRITE, PADDR, PWDATA
    );
endinterface

// File: rtl/apb_cmd_master.sv
// apb_cmd_master: single-outstanding APB3 requester with wait states, PREADY timeout and late read capture
module apb_cmd_master #(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int TIMEOUT    = 16,
    parameter int RDATA_LATE = 1
) (
    input logic              PCLK,
    input logic              PRESETn,
    apb_cmd_master_if.master bus
);
    localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    typedef enum logic [2:0] {IDLE, SETUP, ACCESS, CAPTURE, RESP} state_t;
    state_t            state_q, state_d;
    logic              psel_q, psel_d, penable_q, penable_d, pwrite_q, pwrite_d;
    logic              rsp_valid_q, rsp_valid_d, rsp_err_q, rsp_err_d;
    logic [ADDR_W-1:0] paddr_q, paddr_d;
    logic [DATA_W-1:0] pwdata_q, pwdata_d, rsp_rdata_q, rsp_rdata_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic              timed_out;
    assign timed_out = (TIMEOUT != 0) && (cnt_q == CW'(TIMEOUT - 1));
    always_comb begin
        state_d     = state_q;
        psel_d      = psel_q;
        penable_d   = penable_q;
        pwrite_d    = pwrite_q;
        paddr_d     = paddr_q;
        pwdata_d    = pwdata_q;
        rsp_valid_d = rsp_valid_q;
        rsp_err_d   = rsp_err_q;
        rsp_rdata_d = rsp_rdata_q;
        cnt_d       = cnt_q;
        case (state_q)
            IDLE: if (bus.cmd_valid) begin
                pwrite_d = bus.cmd_write;
                paddr_d  = bus.cmd_addr;
                pwdata_d = bus.cmd_wdata;
                psel_d   = 1'b1;
                state_d  = SETUP;
            end
            SETUP: begin
                penable_d = 1'b1;
                state_d   = ACCESS;
            end
            ACCESS: if (bus.PREADY) begin
                psel_d    = 1'b0;
                penable_d = 1'b0;
                rsp_err_d = bus.PSLVERR;
                if (pwrite_q || RDATA_LATE == 0) begin
                    rsp_rdata_d = pwrite_q ? '0 : bus.PRDATA;
                    rsp_valid_d = 1'b1;
                    state_d     = RESP;
                end else begin
                    state_d = CAPTURE;
                end
            end else begin
                cnt_d = cnt_q + CW'(1);
                if (timed_out) begin
                    psel_d      = 1'b0;
                    penable_d   = 1'b0;
                    rsp_err_d   = 1'b1;
                    rsp_rdata_d = '0;
                    rsp_valid_d = 1'b1;
                    state_d     = RESP;
                end
            end
            // the slave only settles PRDATA on the completing edge, so sample a cycle later
            CAPTURE: begin
                rsp_rdata_d = bus.PRDATA;
                rsp_valid_d = 1'b1;
                state_d     = RESP;
            end
            RESP: if (bus.rsp_ready) begin
                rsp_valid_d = 1'b0;
                cnt_d       = '0;
                state_d     = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end
    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            state_q     <= IDLE;
            psel_q      <= 1'b0;
            penable_q   <= 1'b0;
            pwrite_q    <= 1'b0;
            paddr_q     <= '0;
            pwdata_q    <= '0;
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            rsp_rdata_q <= '0;
            cnt_q       <= '0;
        end else begin
            state_q     <= state_d;
            psel_q      <= psel_d;
            penable_q   <= penable_d;
            pwrite_q    <= pwrite_d;
            paddr_q     <= paddr_d;
            pwdata_q    <= pwdata_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_err_q   <= rsp_err_d;
            rsp_rdata_q <= rsp_rdata_d;
            cnt_q       <= cnt_d;
        end
    end
    assign bus.cmd_ready = (state_q == IDLE);
    assign bus.PSEL      = psel_q;
    assign bus.PENABLE   = penable_q;
    assign bus.PWRITE    = pwrite_q;
    assign bus.PADDR     = paddr_q;
    assign bus.PWDATA    = pwdata_q;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_err   = rsp_err_q;
    assign bus.rsp_rdata = rsp_rdata_q;
endmodule

// File: tb/tb_apb_cmd_master.sv
// tb_apb_cmd_master: randomized bench with a register-slave model and a transaction-level reference
module tb_apb_cmd_master;
    localparam int TO = 16;
    logic PCLK = 1'b0;
    logic PRESETn = 1'b0;
    always #5 PCLK = ~PCLK;
    apb_cmd_master_if #(.ADDR_W(32), .DATA_W(32)) bus_if ();
    apb_cmd_master #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(TO), .RDATA_LATE(1)) dut (
        .PCLK(PCLK), .PRESETn(PRESETn), .bus(bus_if)
    );
    int total = 0;
    int bad = 0;
    int waits = 0;
    bit serr = 1'b0;
    int acc_cnt = 0;
    logic [31:0] smem [16] = '{default: '0};
    logic [31:0] mdl [16];
    // slave: PREADY after 'waits' stalled cycles (negative = never), PRDATA valid only after completion edge
    assign bus_if.PREADY  = (waits >= 0) && (acc_cnt >= waits);
    assign bus_if.PSLVERR = serr;
    always @(posedge PCLK) begin
        acc_cnt <= (bus_if.PSEL && bus_if.PENABLE && !bus_if.PREADY) ? acc_cnt + 1 : 0;
        if (bus_if.PSEL && bus_if.PENABLE && bus_if.PREADY && !bus_if.PWRITE)
            bus_if.PRDATA <= smem[bus_if.PADDR[5:2]];
        else
            bus_if.PRDATA <= $urandom;
        if (bus_if.PSEL && bus_if.PENABLE && bus_if.PREADY && bus_if.PWRITE && !bus_if.PSLVERR)
            smem[bus_if.PADDR[5:2]] <= bus_if.PWDATA;
    end
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time exhausted");
        $fatal(1, "watchdog");
    end

    task automatic model(input bit w, input logic [31:0] a, input logic [31:0] d,
                         output logic [31:0] rd, output logic er, output int lat);
        bit abort;
        abort = (waits < 0);
        rd  = (w || abort) ? 32'h0 : mdl[a[5:2]];
        er  = abort || serr;
        lat = abort ? 2 + TO : 3 + waits + (w ? 0 : 1);
        if (w && !abort && !serr) mdl[a[5:2]] = d;
    endtask

    task automatic run_cmd(input bit w, input logic [31:0] a, input logic [31:0] d, input int hold,
                           output logic [31:0] rd, output logic er, output int lat,
                           output int ps1, output int pe1, output int acc,
                           output bit stable, output bit hold_ok);
        ps1 = 0; pe1 = 0; acc = 0; stable = 1'b1; hold_ok = 1'b1;
        bus_if.cmd_valid = 1'b1;
        bus_if.cmd_write = w;
        bus_if.cmd_addr  = a;
        bus_if.cmd_wdata = d;
        @(posedge PCLK); #1;
        bus_if.cmd_valid = 1'b0;
        lat = 1;
        while (!bus_if.rsp_valid && lat < 60) begin
            if (bus_if.PSEL && ps1 == 0) ps1 = lat;
            if (bus_if.PENABLE && pe1 == 0) pe1 = lat;
            if (bus_if.PSEL && bus_if.PENABLE) acc++;
            if (bus_if.PSEL && {bus_if.PWRITE, bus_if.PADDR, bus_if.PWDATA} !== {w, a, d}) stable = 1'b0;
            @(posedge PCLK); #1;
            lat++;
        end
        rd = bus_if.rsp_rdata;
        er = bus_if.rsp_err;
        for (int i = 0; i < hold; i++) begin
            @(posedge PCLK); #1;
            if (!bus_if.rsp_valid || bus_if.cmd_ready || bus_if.rsp_rdata !== rd || bus_if.rsp_err !== er)
                hold_ok = 1'b0;
        end
        bus_if.rsp_ready = 1'b1;
        @(posedge PCLK); #1;
        bus_if.rsp_ready = 1'b0;
    endtask

    task automatic test_reset();
        total++;
        if ({bus_if.PSEL, bus_if.PENABLE, bus_if.PWRITE, bus_if.PADDR, bus_if.PWDATA,
             bus_if.rsp_valid, bus_if.rsp_rdata, bus_if.rsp_err} !== '0) begin
            bad++;
            $display("FAIL reset_outputs: got psel=%b pen=%b pwr=%b paddr=%h pwdata=%h rv=%b rd=%h re=%b want all 0",
                     bus_if.PSEL, bus_if.PENABLE, bus_if.PWRITE, bus_if.PADDR, bus_if.PWDATA,
                     bus_if.rsp_valid, bus_if.rsp_rdata, bus_if.rsp_err);
        end
        total++;
        if (bus_if.cmd_ready !== 1'b1) begin
            bad++;
            $display("FAIL reset_cmd_ready: got %b want 1", bus_if.cmd_ready);
        end
    endtask

    task automatic test_write();
        logic [31:0] rd, erd; logic er, eer; int lat, elat, ps1, pe1, acc; bit st, ho;
        waits = 0; serr = 1'b0;
        model(1'b1, 32'h0, 32'hDEADBEEF, erd, eer, elat);
        run_cmd(1'b1, 32'h0, 32'hDEADBEEF, 0, rd, er, lat, ps1, pe1, acc, st, ho);
        total++; if (ps1 !== 1) begin bad++; $display("FAIL write_psel_cycle: got %0d want 1", ps1); end
        total++; if (pe1 !== 2) begin bad++; $display("FAIL write_penable_cycle: got %0d want 2", pe1); end
        total++; if (lat !== elat) begin bad++; $display("FAIL write_latency: got %0d want %0d", lat, elat); end
        total++; if (er !== eer) begin bad++; $display("FAIL write_err: got %b want %b", er, eer); end
        total++; if (rd !== erd) begin bad++; $display("FAIL write_rdata: got %h want %h", rd, erd); end
    endtask

    task automatic test_read_late();
        logic [31:0] rd, erd; logic er, eer; int lat, elat, ps1, pe1, acc; bit st, ho;
        waits = 0; serr = 1'b0;
        model(1'b0, 32'h0, 32'h0, erd, eer, elat);
        run_cmd(1'b0, 32'h0, 32'h0, 0, rd, er, lat, ps1, pe1, acc, st, ho);
        total++; if (rd !== erd) begin bad++; $display("FAIL read_late_rdata: got %h want %h", rd, erd); end
        total++; if (lat !== elat) begin bad++; $display("FAIL read_late_latency: got %0d want %0d", lat, elat); end
        total++; if (er !== eer) begin bad++; $display("FAIL read_late_err: got %b want %b", er, eer); end
    endtask

    task automatic test_wait_states();
        logic [31:0] a, d, rd, erd; logic er, eer; int lat, elat, ps1, pe1, acc; bit st, ho;
        a = {26'h0, 4'($urandom_range(0, 15)), 2'b00};
        d = $urandom;
        waits = 3; serr = 1'b0;
        model(1'b1, a, d, erd, eer, elat);
        run_cmd(1'b1, a, d, 0, rd, er, lat, ps1, pe1, acc, st, ho);
        total++; if (acc !== 4) begin bad++; $display("FAIL wait_access_cycles: got %0d want 4", acc); end
        total++; if (st !== 1'b1) begin bad++; $display("FAIL wait_stable: got %b want 1", st); end
        total++; if (lat !== elat) begin bad++; $display("FAIL wait_latency: got %0d want %0d", lat, elat); end
        total++; if (er !== eer) begin bad++; $display("FAIL wait_err: got %b want %b", er, eer); end
        model(1'b0, a, 32'h0, erd, eer, elat);
        run_cmd(1'b0, a, 32'h0, 0, rd, er, lat, ps1, pe1, acc, st, ho);
        total++; if (rd !== erd) begin bad++; $display("FAIL wait_readback: got %h want %h", rd, erd); end
        total++; if (lat !== elat) begin bad++; $display("FAIL wait_read_latency: got %0d want %0d", lat, elat); end
    endtask

    task automatic test_timeout();
        logic [31:0] a, d, rd, erd; logic er, eer; int lat, elat, ps1, pe1, acc; bit st, ho;
        a = {26'h0, 4'($urandom_range(0, 15)), 2'b00};
        d = $urandom;
        waits = -1; serr = 1'b0;
        model(1'b1, a, d, erd, eer, elat);
        run_cmd(1'b1, a, d, 0, rd, er, lat, ps1, pe1, acc, st, ho);
        total++; if (acc !== TO) begin bad++; $display("FAIL timeout_access_cycles: got %0d want %0d", acc, TO); end
        total++; if (lat !== elat) begin bad++; $display("FAIL timeout_latency: got %0d want %0d", lat, elat); end
        total++; if (er !== eer) begin bad++; $display("FAIL timeout_err: got %b want %b", er, eer); end
        total++; if (rd !== erd) begin bad++; $display("FAIL timeout_rdata: got %h want %h", rd, erd); end
        waits = 0;
        model(1'b0, a, 32'h0, erd, eer, elat);
        run_cmd(1'b0, a, 32'h0, 0, rd, er, lat, ps1, pe1, acc, st, ho);
        total++; if ({rd, er} !== {erd, eer}) begin bad++; $display("FAIL timeout_next_cmd: got %h/%b want %h/%b", rd, er, erd, eer); end
        total++; if (lat !== elat) begin bad++; $display("FAIL timeout_next_latency: got %0d want %0d", lat, elat); end
    endtask

    task automatic test_slverr_hold();
        logic [31:0] a, rd, erd; logic er, eer; int lat, elat, ps1, pe1, acc; bit st, ho;
        a = {26'h0, 4'($urandom_range(0, 15)), 2'b00};
        waits = 0; serr = 1'b1;
        model(1'b0, a, 32'h0, erd, eer, elat);
        run_cmd(1'b0, a, 32'h0, 5, rd, er, lat, ps1, pe1, acc, st, ho);
        serr = 1'b0;
        total++; if (er !== eer) begin bad++; $display("FAIL slverr_err: got %b want %b", er, eer); end
        total++; if (rd !== erd) begin bad++; $display("FAIL slverr_rdata: got %h want %h", rd, erd); end
        total++; if (ho !== 1'b1) begin bad++; $display("FAIL slverr_hold: got %b want 1", ho); end
    endtask

    task automatic test_back_to_back();
        logic [31:0] a, d, rd, erd; logic er, eer; int lat, elat, ps1, pe1, acc; bit st, ho, w;
        for (int n = 0; n < 40; n++) begin
            w = 1'($urandom_range(0, 1));
            a = {26'h0, 4'($urandom_range(0, 15)), 2'b00};
            d = $urandom;
            waits = $urandom_range(0, 4);
            serr = ($urandom_range(0, 9) == 0);
            model(w, a, d, erd, eer, elat);
            run_cmd(w, a, d, 0, rd, er, lat, ps1, pe1, acc, st, ho);
            total++; if ({rd, er} !== {erd, eer}) begin bad++; $display("FAIL rand_rsp[%0d]: got %h/%b want %h/%b", n, rd, er, erd, eer); end
            total++; if (lat !== elat) begin bad++; $display("FAIL rand_latency[%0d]: got %0d want %0d", n, lat, elat); end
            total++; if (st !== 1'b1) begin bad++; $display("FAIL rand_stable[%0d]: got %b want 1", n, st); end
        end
        waits = 0; serr = 1'b0;
    endtask

    task automatic test_reset_mid();
        logic [31:0] a, rd, erd; logic er, eer; int lat, elat, ps1, pe1, acc; bit st, ho, ok_v, ok_r;
        a = {26'h0, 4'($urandom_range(0, 15)), 2'b00};
        waits = 5; serr = 1'b0;
        bus_if.cmd_valid = 1'b1; bus_if.cmd_write = 1'b1; bus_if.cmd_addr = a; bus_if.cmd_wdata = $urandom;
        @(posedge PCLK); #1;
        bus_if.cmd_valid = 1'b0;
        repeat (2) @(posedge PCLK);
        #2;
        total++; if ({bus_if.PSEL, bus_if.PENABLE} !== 2'b11) begin bad++; $display("FAIL rstmid_in_access: got %b want 11", {bus_if.PSEL, bus_if.PENABLE}); end
        PRESETn = 1'b0;
        #1;
        total++;
        if ({bus_if.PSEL, bus_if.PENABLE, bus_if.PWRITE, bus_if.PADDR, bus_if.PWDATA,
             bus_if.rsp_valid, bus_if.rsp_rdata, bus_if.rsp_err} !== '0) begin
            bad++;
            $display("FAIL rstmid_async_clear: got psel=%b pen=%b pwr=%b paddr=%h rv=%b re=%b want all 0",
                     bus_if.PSEL, bus_if.PENABLE, bus_if.PWRITE, bus_if.PADDR, bus_if.rsp_valid, bus_if.rsp_err);
        end
        @(negedge PCLK);
        PRESETn = 1'b1;
        waits = 0;
        ok_v = 1'b1; ok_r = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(posedge PCLK); #1;
            if (bus_if.rsp_valid !== 1'b0) ok_v = 1'b0;
            if (bus_if.cmd_ready !== 1'b1) ok_r = 1'b0;
        end
        total++; if (ok_v !== 1'b1) begin bad++; $display("FAIL rstmid_no_rsp: got %b want 1", ok_v); end
        total++; if (ok_r !== 1'b1) begin bad++; $display("FAIL rstmid_cmd_ready: got %b want 1", ok_r); end
        model(1'b0, a, 32'h0, erd, eer, elat);
        run_cmd(1'b0, a, 32'h0, 0, rd, er, lat, ps1, pe1, acc, st, ho);
        total++; if ({rd, er} !== {erd, eer}) begin bad++; $display("FAIL rstmid_next_read: got %h/%b want %h/%b", rd, er, erd, eer); end
    endtask

    initial begin
        for (int i = 0; i < 16; i++) mdl[i] = '0;
        bus_if.cmd_valid = 1'b0; bus_if.cmd_write = 1'b0;
        bus_if.cmd_addr = '0; bus_if.cmd_wdata = '0; bus_if.rsp_ready = 1'b0;
        repeat (2) @(posedge PCLK);
        @(negedge PCLK);
        PRESETn = 1'b1;
        @(posedge PCLK); #1;
        test_reset();
        test_write();
        test_read_late();
        test_wait_states();
        test_timeout();
        test_slverr_hold();
        test_back_to_back();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
